// File: rtl/gpio_bus_arbiter_pkg.sv
// rtl/gpio_bus_arbiter_pkg.sv - shared types and constants for the gpio bus arbiter
// Purpose: FSM state encoding and the default read data returned on a timeout completion.
// Ports: none (package).
package gpio_bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/gpio_bus_arbiter_if.sv
// rtl/gpio_bus_arbiter_if.sv - requester and slave bus bundle for the gpio bus arbiter
// Purpose: groups the requester-side (req_*) and slave-side (m_*) signals plus grant/busy status.
// Ports (modport master = arbiter view):
//   in : req_valid[NREQ], req_addr[32*NREQ], req_wstrb[NREQ], req_wdata[32*NREQ], m_rdata[32], m_ready
//   out: req_ready[NREQ], req_rdata[32], req_err, m_valid, m_addr[32], m_wstrb, m_wdata[32],
//        grant[NREQ], busy
//   modport slave is the mirror image, used by the environment around the arbiter.
interface gpio_bus_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_addr;
  logic [NREQ-1:0]      req_wstrb;
  logic [32*NREQ-1:0]   req_wdata;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          req_rdata;
  logic                 req_err;
  logic                 m_valid;
  logic [31:0]          m_addr;
  logic                 m_wstrb;
  logic [31:0]          m_wdata;
  logic [31:0]          m_rdata;
  logic                 m_ready;
  logic [NREQ-1:0]      grant;
  logic                 busy;

  modport master (
    input  req_valid, req_addr, req_wstrb, req_wdata, m_rdata, m_ready,
    output req_ready, req_rdata, req_err, m_valid, m_addr, m_wstrb, m_wdata, grant, busy
  );

  modport slave (
    output req_valid, req_addr, req_wstrb, req_wdata, m_rdata, m_ready,
    input  req_ready, req_rdata, req_err, m_valid, m_addr, m_wstrb, m_wdata, grant, busy
  );
endinterface

// File: rtl/gpio_bus_arbiter_rr_pick.sv
// rtl/gpio_bus_arbiter_rr_pick.sv - combinational round-robin picker
// Purpose: finds the first asserted request searching last+1, last+2, ... (mod NREQ).
// Ports:
//   req  in  NREQ  request vector
//   last in  IW    index granted most recently
//   any  out 1     at least one request asserted
//   idx  out IW    winning index (0 when any is low)
module rr_pick #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest asserted
  // request after 'last' is the one left standing.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// rtl/gpio_bus_arbiter.sv - round-robin arbiter sharing one iomem-style gpio slave
// Purpose: latches the round-robin winner's request, drives it to the slave until m_ready or
//   timeout, and returns the completion pulse/data to the granted requester only.
// Ports:
//   clk     in  clock, rising edge
//   resetn  in  synchronous active-low reset
//   bus     gpio_bus_arbiter_if.master: req_* requester side, m_* slave side, grant, busy
module gpio_bus_arbiter
  import gpio_bus_arbiter_pkg::*;
#(
  parameter int          NREQ     = 2,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  gpio_bus_arbiter_if.master   bus
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_grant;
  logic [TW-1:0]   timer;
  logic [NREQ-1:0] grant_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            wstrb_q;
  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic            done;
  logic            timed_out;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (bus.req_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_grant <= IW'(NREQ - 1);
      timer      <= '0;
      grant_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        if (pick_any) begin
          owner   <= pick_idx;
          grant_q <= NREQ'(1) << pick_idx;
          addr_q  <= bus.req_addr[32*pick_idx +: 32];
          wdata_q <= bus.req_wdata[32*pick_idx +: 32];
          wstrb_q <= bus.req_wstrb[pick_idx];
          timer   <= '0;
        end
      end else if (done) begin
        grant_q    <= '0;
        last_grant <= owner;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // A slave response in the final timer cycle still counts as a normal completion.
  always_comb begin
    state_nxt     = state;
    done          = 1'b0;
    timed_out     = 1'b0;
    bus.req_ready = '0;
    bus.req_rdata = '0;
    bus.req_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        timed_out = !bus.m_ready && (timer == TW'(TIMEOUT - 1));
        done      = bus.m_ready || timed_out;
        if (done) begin
          state_nxt     = ST_IDLE;
          bus.req_ready = NREQ'(1) << owner;
          bus.req_rdata = timed_out ? ERR_DATA : bus.m_rdata;
          bus.req_err   = timed_out;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.m_valid = (state == ST_BUSY);
  assign bus.busy    = (state == ST_BUSY);
  assign bus.grant   = grant_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_wstrb = wstrb_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb/tb_gpio_bus_arbiter.sv - self-checking bench for gpio_bus_arbiter (NREQ=2 and NREQ=4 instances)
module tb_gpio_bus_arbiter;
  import gpio_bus_arbiter_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  gpio_bus_arbiter_if #(.NREQ(2)) b2 ();
  gpio_bus_arbiter_if #(.NREQ(4)) b4 ();

  gpio_bus_arbiter #(.NREQ(2), .TIMEOUT(TO)) u_dut2 (.clk(clk), .resetn(resetn), .bus(b2.master));
  gpio_bus_arbiter #(.NREQ(4), .TIMEOUT(TO)) u_dut4 (.clk(clk), .resetn(resetn), .bus(b4.master));

  typedef struct {
    int          who;
    logic [31:0] rdata;
    logic        err;
    int          bcnt;
    int          cyc;
  } ev_t;

  ev_t log2q[$];
  ev_t log4q[$];
  ev_t ev;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // requester / slave stub state, index 0 -> NREQ=2 instance, 1 -> NREQ=4 instance
  int          pend   [2][4];
  logic [31:0] r_addr [2][4];
  logic [31:0] r_wdata[2][4];
  logic        r_wr   [2][4];
  logic        hang   [2];
  logic        stray  [2];
  int          scnt   [2];
  logic [31:0] regs   [2][4];

  // behavioural model state
  int          nreq [2] = '{2, 4};
  int          own  [2] = '{-1, -1};
  int          age  [2] = '{0, 0};
  int          last [2] = '{1, 3};
  logic [31:0] l_addr[2], l_wdata[2];
  logic        l_wr[2];
  int          bc[2] = '{0, 0};

  logic [3:0]  a_grant[2], a_rr[2], i_rv[2];
  logic        a_busy[2], a_err[2], a_mv[2], a_mw[2], i_mr[2];
  logic [31:0] a_rd[2], a_ma[2], a_md[2], i_mrd[2];
  logic [31:0] i_addr[2][4], i_wd[2][4];
  logic        i_wr[2][4];
  logic [3:0]  e_grant, e_rr;
  logic [31:0] e_rd;
  logic        e_err, e_done;
  int          w, j;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic stub(input int d, input logic mv, input logic [31:0] ma, input logic mw,
                      input logic [31:0] md, output logic rdy, output logic [31:0] rd);
    rdy = 1'b0;
    rd  = '0;
    if (mv === 1'b1) begin
      if (!hang[d] && scnt[d] == 1) begin
        rdy = 1'b1;
        rd  = regs[d][ma[3:2]];
        if (mw) regs[d][ma[3:2]] = md;
      end
      scnt[d]++;
    end else begin
      scnt[d]  = 0;
      rdy      = stray[d];
      stray[d] = 1'b0;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 2; i++) begin
      b2.req_valid[i]          = (pend[0][i] > 0);
      b2.req_addr[32*i +: 32]  = r_addr[0][i];
      b2.req_wstrb[i]          = r_wr[0][i];
      b2.req_wdata[32*i +: 32] = r_wdata[0][i];
    end
    for (int i = 0; i < 4; i++) begin
      b4.req_valid[i]          = (pend[1][i] > 0);
      b4.req_addr[32*i +: 32]  = r_addr[1][i];
      b4.req_wstrb[i]          = r_wr[1][i];
      b4.req_wdata[32*i +: 32] = r_wdata[1][i];
    end
    stub(0, b2.m_valid, b2.m_addr, b2.m_wstrb, b2.m_wdata, b2.m_ready, b2.m_rdata);
    stub(1, b4.m_valid, b4.m_addr, b4.m_wstrb, b4.m_wdata, b4.m_ready, b4.m_rdata);
  endtask

  // Requesters hold req_valid until their ready pulse; the slave stub answers in the
  // second m_valid cycle unless told to hang.
  initial begin : drv
    logic [3:0] rr [2];
    for (int d = 0; d < 2; d++) begin
      hang[d] = 1'b0; stray[d] = 1'b0; scnt[d] = 0;
      for (int i = 0; i < 4; i++) begin
        pend[d][i] = 0; r_addr[d][i] = '0; r_wdata[d][i] = '0; r_wr[d][i] = 1'b0; regs[d][i] = '0;
      end
    end
    regs[0][1] = 32'h0000_00FF;
    apply();
    forever begin
      @(negedge clk);
      rr[0] = {2'b00, b2.req_ready};
      rr[1] = b4.req_ready;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++)
          if (rr[d][i] === 1'b1 && pend[d][i] > 0) pend[d][i]--;
      apply();
    end
  end

  always @(negedge clk) begin : cmp
    cyc++;
    a_busy[0] = b2.busy; a_grant[0] = {2'b00, b2.grant}; a_rr[0] = {2'b00, b2.req_ready};
    a_rd[0] = b2.req_rdata; a_err[0] = b2.req_err; a_mv[0] = b2.m_valid; a_ma[0] = b2.m_addr;
    a_mw[0] = b2.m_wstrb; a_md[0] = b2.m_wdata; i_rv[0] = {2'b00, b2.req_valid};
    i_mr[0] = b2.m_ready; i_mrd[0] = b2.m_rdata;
    a_busy[1] = b4.busy; a_grant[1] = b4.grant; a_rr[1] = b4.req_ready;
    a_rd[1] = b4.req_rdata; a_err[1] = b4.req_err; a_mv[1] = b4.m_valid; a_ma[1] = b4.m_addr;
    a_mw[1] = b4.m_wstrb; a_md[1] = b4.m_wdata; i_rv[1] = b4.req_valid;
    i_mr[1] = b4.m_ready; i_mrd[1] = b4.m_rdata;
    for (int i = 0; i < 2; i++) begin
      i_addr[0][i] = b2.req_addr[32*i +: 32]; i_wd[0][i] = b2.req_wdata[32*i +: 32]; i_wr[0][i] = b2.req_wstrb[i];
    end
    for (int i = 0; i < 4; i++) begin
      i_addr[1][i] = b4.req_addr[32*i +: 32]; i_wd[1][i] = b4.req_wdata[32*i +: 32]; i_wr[1][i] = b4.req_wstrb[i];
    end

    for (int d = 0; d < 2; d++) begin
      // expected outputs this cycle
      e_done = 1'b0; e_rd = '0; e_err = 1'b0; e_grant = '0; e_rr = '0;
      if (own[d] >= 0) begin
        e_grant = 4'(1 << own[d]);
        if (i_mr[d] === 1'b1) begin
          e_done = 1'b1; e_rd = i_mrd[d];
        end else if (age[d] == TO - 1) begin
          e_done = 1'b1; e_rd = 32'hDEAD_BEEF; e_err = 1'b1;
        end
        if (e_done) e_rr = e_grant;
      end
      chk($sformatf("n%0d_busy", nreq[d]), 32'(a_busy[d]), 32'(own[d] >= 0));
      chk($sformatf("n%0d_m_valid", nreq[d]), 32'(a_mv[d]), 32'(own[d] >= 0));
      chk($sformatf("n%0d_grant", nreq[d]), 32'(a_grant[d]), 32'(e_grant));
      chk($sformatf("n%0d_req_ready", nreq[d]), 32'(a_rr[d]), 32'(e_rr));
      chk($sformatf("n%0d_req_rdata", nreq[d]), a_rd[d], e_rd);
      chk($sformatf("n%0d_req_err", nreq[d]), 32'(a_err[d]), 32'(e_err));
      if (own[d] >= 0) begin
        chk($sformatf("n%0d_m_addr", nreq[d]), a_ma[d], l_addr[d]);
        chk($sformatf("n%0d_m_wstrb", nreq[d]), 32'(a_mw[d]), 32'(l_wr[d]));
        chk($sformatf("n%0d_m_wdata", nreq[d]), a_md[d], l_wdata[d]);
      end

      // completion log from what the DUT actually did
      if (a_busy[d] === 1'b1) bc[d]++; else bc[d] = 0;
      if (a_rr[d] !== 4'b0000) begin
        ev.who = -1;
        for (int i = 0; i < 4; i++) if (a_rr[d][i] === 1'b1) ev.who = i;
        ev.rdata = a_rd[d]; ev.err = a_err[d]; ev.bcnt = bc[d]; ev.cyc = cyc;
        if (d == 0) log2q.push_back(ev); else log4q.push_back(ev);
      end

      // advance the model across the coming edge
      if (resetn !== 1'b1) begin
        own[d] = -1; age[d] = 0; last[d] = nreq[d] - 1;
      end else if (own[d] < 0) begin
        w = -1;
        for (int k = 1; k <= nreq[d]; k++) begin
          j = (last[d] + k) % nreq[d];
          if (w < 0 && i_rv[d][j] === 1'b1) w = j;
        end
        if (w >= 0) begin
          own[d] = w; age[d] = 0;
          l_addr[d] = i_addr[d][w]; l_wdata[d] = i_wd[d][w]; l_wr[d] = i_wr[d][w];
        end
      end else if (e_done) begin
        last[d] = own[d]; own[d] = -1;
      end else begin
        age[d]++;
      end
    end
  end

  task automatic wait_log(input int d, input int n, input int budget, input string nm);
    int b;
    b = budget;
    while (((d == 0) ? log2q.size() : log4q.size()) < n && b > 0) begin
      @(posedge clk);
      b--;
    end
    #2;
    if (((d == 0) ? log2q.size() : log4q.size()) < n) begin
      total++; bad++;
      $display("FAIL %s: timed out with %0d completions, want %0d", nm, (d == 0) ? log2q.size() : log4q.size(), n);
    end
  endtask

  function automatic ev_t get2(input int k);
    ev_t e;
    e = '{who: -1, rdata: '0, err: 1'b0, bcnt: 0, cyc: 0};
    if (k < log2q.size()) e = log2q[k];
    return e;
  endfunction

  function automatic ev_t get4(input int k);
    ev_t e;
    e = '{who: -1, rdata: '0, err: 1'b0, bcnt: 0, cyc: 0};
    if (k < log4q.size()) e = log4q[k];
    return e;
  endfunction

  initial begin : main
    int base;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(b2.busy), 32'd0);
    chk("rst_grant", 32'(b2.grant), 32'd0);
    chk("rst_m_valid", 32'(b4.m_valid), 32'd0);

    // single read by requester 0
    @(posedge clk); #2;
    r_addr[0][0] = 32'h04; r_wr[0][0] = 1'b0; pend[0][0] = 1;
    wait_log(0, 1, 20, "t1_wait");
    chk("t1_who", 32'(get2(0).who), 32'd0);
    chk("t1_rdata", get2(0).rdata, 32'h0000_00FF);
    chk("t1_err", 32'(get2(0).err), 32'd0);
    chk("t1_latency", 32'(get2(0).bcnt), 32'd2);

    // write by requester 1
    @(posedge clk); #2;
    r_addr[0][1] = 32'h00; r_wr[0][1] = 1'b1; r_wdata[0][1] = 32'hA5A5_0000; pend[0][1] = 1;
    wait_log(0, 2, 20, "t3_wait");
    chk("t3_who", 32'(get2(1).who), 32'd1);
    chk("t3_err", 32'(get2(1).err), 32'd0);
    chk("t3_gpio_out", regs[0][0], 32'hA5A5_0000);

    // timeout, then a stray m_ready while idle
    @(posedge clk); #2;
    hang[0] = 1'b1; r_addr[0][0] = 32'h08; pend[0][0] = 1;
    wait_log(0, 3, 40, "t4_wait");
    chk("t4_err", 32'(get2(2).err), 32'd1);
    chk("t4_rdata", get2(2).rdata, 32'hDEAD_BEEF);
    chk("t4_busy_cycles", 32'(get2(2).bcnt), 32'd16);
    repeat (2) @(posedge clk); #2;
    stray[0] = 1'b1;
    repeat (4) @(posedge clk); #2;
    chk("t4_stray_no_pulse", 32'(log2q.size()), 32'd3);

    // reset in the middle of a transaction
    pend[0][1] = 1;
    repeat (5) @(posedge clk); #2;
    resetn = 1'b0; pend[0][0] = 1;
    @(posedge clk); #2;
    hang[0] = 1'b0; resetn = 1'b1;
    chk("t5_no_pulse", 32'(log2q.size()), 32'd3);
    wait_log(0, 5, 30, "t5_wait");
    chk("t5_first", 32'(get2(3).who), 32'd0);
    chk("t5_second", 32'(get2(4).who), 32'd1);

    // contention from reset: both held for two transactions each
    @(posedge clk); #2;
    resetn = 1'b0;
    @(posedge clk); #2;
    resetn = 1'b1; pend[0][0] = 2; pend[0][1] = 2;
    base = log2q.size();
    wait_log(0, base + 4, 60, "t2_wait");
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_order%0d", k), 32'(get2(base + k).who), 32'(k % 2));
    for (int k = 1; k < 4; k++)
      chk($sformatf("t2_gap%0d", k), 32'(get2(base + k).cyc - get2(base + k - 1).cyc), 32'd3);

    // rotation with four requesters: leave last_grant at 2, then ask {0,1,3}
    @(posedge clk); #2;
    pend[1][2] = 1;
    wait_log(1, 1, 20, "t6_setup");
    chk("t6_setup_who", 32'(get4(0).who), 32'd2);
    @(posedge clk); #2;
    pend[1][0] = 1; pend[1][1] = 1; pend[1][3] = 1;
    wait_log(1, 4, 40, "t6_wait");
    chk("t6_first", 32'(get4(1).who), 32'd3);
    chk("t6_second", 32'(get4(2).who), 32'd0);
    chk("t6_third", 32'(get4(3).who), 32'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1, "watchdog");
  end

endmodule
